// File: rtl/pool_aurora_framer.sv
// Pool FIFO to Aurora LocalLink framer: header, sequence, PAYLOAD_LEN payload words, checksum.
// Payload is staged through a 2-entry skid buffer fed by the 1-cycle-latency FIFO read port.
module pool_aurora_framer #(
  parameter int unsigned PAYLOAD_LEN = 256,
  parameter logic [15:0] HEADER_WORD = 16'hA5C3,
  parameter logic [15:0] PAD_WORD    = 16'hDEAD,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_rd_empty,
  input  logic [15:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic [15:0] tx_d,
  output logic        tx_src_rdy_n,
  output logic        tx_sof_n,
  output logic        tx_eof_n,
  input  logic        tx_dst_rdy_n,
  output logic        frame_done,
  output logic        underrun,
  output logic [15:0] frame_count
);
  localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(PAYLOAD_LEN);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST_C = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_PAYLOAD, S_CSUM} state_t;
  state_t state_q, state_d;

  logic [15:0]      sb_q [2];
  logic [15:0]      sb_d [2];
  logic             sb_rd_ptr_q, sb_rd_ptr_d;
  logic             sb_wr_ptr_q, sb_wr_ptr_d;
  logic [1:0]       sb_cnt_q, sb_cnt_d;
  logic             rd_pend_q;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             pad_q, pad_d;
  logic [15:0]      csum_q, csum_d;
  logic [15:0]      seq_q, seq_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             frame_done_q, frame_done_d;
  logic             underrun_q, underrun_d;

  logic       src_rdy, beat, pop, push, sb_has;
  logic [1:0] occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enable && !fifo_rd_empty) state_d = S_HDR;
      S_HDR:     if (beat) state_d = S_SEQ;
      S_SEQ:     if (beat) state_d = S_PAYLOAD;
      S_PAYLOAD: if (beat && pay_cnt_q == LAST_C) state_d = S_CSUM;
      S_CSUM:    if (beat) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // A landing in-flight word must go out before any pad word, so hold off while one is pending.
  always_comb begin
    src_rdy  = 1'b0;
    tx_d     = '0;
    tx_sof_n = 1'b1;
    tx_eof_n = 1'b1;
    case (state_q)
      S_HDR: begin
        src_rdy  = 1'b1;
        tx_d     = HEADER_WORD;
        tx_sof_n = 1'b0;
      end
      S_SEQ: begin
        src_rdy = 1'b1;
        tx_d    = seq_q;
      end
      S_PAYLOAD: begin
        src_rdy = sb_has || (pad_q && !rd_pend_q);
        tx_d    = sb_has ? sb_q[sb_rd_ptr_q] : PAD_WORD;
      end
      S_CSUM: begin
        src_rdy  = 1'b1;
        tx_d     = csum_q;
        tx_eof_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign tx_src_rdy_n = ~src_rdy;
  assign beat         = src_rdy && !tx_dst_rdy_n;
  assign sb_has       = (sb_cnt_q != 2'd0);
  assign pop          = (state_q == S_PAYLOAD) && beat && sb_has;
  assign push         = rd_pend_q;
  // Occupancy after this cycle's pop, so one read per cycle sustains a full-rate stream.
  assign occ          = sb_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  assign fifo_rd_en   = (state_q == S_HDR || state_q == S_SEQ || state_q == S_PAYLOAD) &&
                        !fifo_rd_empty && !pad_q && (rd_cnt_q < LEN_C) && (occ < 2'd2);

  always_comb begin
    sb_d          = sb_q;
    sb_rd_ptr_d   = sb_rd_ptr_q;
    sb_wr_ptr_d   = sb_wr_ptr_q;
    sb_cnt_d      = sb_cnt_q + {1'b0, push} - {1'b0, pop};
    rd_cnt_d      = rd_cnt_q + CNT_W'(fifo_rd_en);
    pay_cnt_d     = pay_cnt_q;
    csum_d        = csum_q;
    seq_d         = seq_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    underrun_d    = 1'b0;
    pad_d         = pad_q;
    to_cnt_d      = '0;
    if (push) begin
      sb_d[sb_wr_ptr_q] = fifo_rd_data;
      sb_wr_ptr_d       = ~sb_wr_ptr_q;
    end
    if (pop) sb_rd_ptr_d = ~sb_rd_ptr_q;
    if (state_q == S_IDLE) rd_cnt_d = '0;
    if (state_q == S_SEQ && beat) begin
      pay_cnt_d = '0;
      csum_d    = '0;
    end
    if (state_q == S_PAYLOAD) begin
      to_cnt_d = to_cnt_q;
      if (beat) begin
        pay_cnt_d = pay_cnt_q + 1'b1;
        csum_d    = csum_q + tx_d;
        to_cnt_d  = '0;
      end else if (!sb_has && !pad_q) begin
        if (to_cnt_q == TO_LAST_C) begin
          pad_d      = 1'b1;
          underrun_d = 1'b1;
          to_cnt_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    end else begin
      pad_d = 1'b0;
    end
    if (state_q == S_CSUM && beat) begin
      frame_done_d  = 1'b1;
      seq_d         = seq_q + 16'd1;
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) sb_q[i] <= '0;
      sb_rd_ptr_q   <= 1'b0;
      sb_wr_ptr_q   <= 1'b0;
      sb_cnt_q      <= '0;
      rd_pend_q     <= 1'b0;
      rd_cnt_q      <= '0;
      pay_cnt_q     <= '0;
      to_cnt_q      <= '0;
      pad_q         <= 1'b0;
      csum_q        <= '0;
      seq_q         <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      sb_q          <= sb_d;
      sb_rd_ptr_q   <= sb_rd_ptr_d;
      sb_wr_ptr_q   <= sb_wr_ptr_d;
      sb_cnt_q      <= sb_cnt_d;
      rd_pend_q     <= fifo_rd_en;
      rd_cnt_q      <= rd_cnt_d;
      pay_cnt_q     <= pay_cnt_d;
      to_cnt_q      <= to_cnt_d;
      pad_q         <= pad_d;
      csum_q        <= csum_d;
      seq_q         <= seq_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      underrun_q    <= underrun_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign underrun    = underrun_q;
  assign frame_count = frame_count_q;

endmodule
